// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame
// Description : UART receive frame assembler. Samples data, optional parity
//               and stop bit once per bit period after a confirmed start bit.
// Revision    : 1.0
// ============================================================================
module uart_rx_frame #(
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX_in,
    input  logic                 de_strtbit,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 par_err,
    output logic                 frm_err,
    output logic                 busy
);
    localparam int CNT_W = $clog2(OVS);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(OVS - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_data  = 3'd1;
    localparam logic [2:0] c_par   = 3'd2;
    localparam logic [2:0] c_stop  = 3'd3;
    localparam logic [2:0] c_break = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_mis;
    logic                 w_tick;
    logic                 w_counting;
    logic                 w_par_exp;

    assign w_tick    = (r_cnt == c_cnt_last);
    assign w_par_exp = (^r_shift) ^ (PARITY == 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (de_strtbit) w_next_state = c_data;
            c_data:  if (w_tick && (r_idx == c_idx_last))
                         w_next_state = (PARITY != 0) ? c_par : c_stop;
            c_par:   if (w_tick) w_next_state = c_stop;
            c_stop:  if (w_tick) w_next_state = RX_in ? c_idle : c_break;
            // A held-low line parks here so it cannot spawn further frames
            c_break: if (RX_in) w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        busy       = (r_state != c_idle);
        w_counting = (r_state == c_data) || (r_state == c_par) || (r_state == c_stop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_mis <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (r_state == c_idle) begin
                r_cnt <= '0;
                r_idx <= '0;
                if (de_strtbit) r_par_mis <= 1'b0;
            end else if (w_counting) begin
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                if (w_tick) begin
                    case (r_state)
                        c_data: begin
                            r_shift <= {RX_in, r_shift[DATA_BITS-1:1]};
                            r_idx   <= r_idx + 1'b1;
                        end
                        c_par:  r_par_mis <= RX_in ^ w_par_exp;
                        c_stop: begin
                            rx_data  <= r_shift;
                            rx_valid <= 1'b1;
                            par_err  <= r_par_mis;
                            frm_err  <= ~RX_in;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_frame
// Description : Directed scoreboard bench for uart_rx_frame (no parity and
//               even-parity instances sharing clock, line and reset).
// Revision    : 1.0
// ============================================================================
module tb_uart_rx_frame;
    localparam int OVS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_line;
    logic       de0, de1;
    logic [7:0] rx_data0, rx_data1;
    logic       v0, v1, pe0, pe1, fe0, fe1, busy0, busy1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       frm;
        int         at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_frame #(.OVS(OVS), .DATA_BITS(8), .PARITY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .RX_in(rx_line), .de_strtbit(de0),
        .rx_data(rx_data0), .rx_valid(v0), .par_err(pe0), .frm_err(fe0), .busy(busy0)
    );

    uart_rx_frame #(.OVS(OVS), .DATA_BITS(8), .PARITY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .RX_in(rx_line), .de_strtbit(de1),
        .rx_data(rx_data1), .rx_valid(v1), .par_err(pe1), .frm_err(fe1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic score(input int sel, input logic v, input logic [7:0] d,
                         input logic p, input logic f);
        exp_t e;
        int   n;
        if (v !== 1'b0) begin
            n = (sel == 0) ? q0.size() : q1.size();
            check($sformatf("dut%0d_valid_scheduled", sel), (n > 0), 1);
            if (n > 0) begin
                if (sel == 0) e = q0.pop_front();
                else          e = q1.pop_front();
                check($sformatf("dut%0d_rx_data", sel), d, e.data);
                check($sformatf("dut%0d_par_err", sel), p, e.par);
                check($sformatf("dut%0d_frm_err", sel), f, e.frm);
                check($sformatf("dut%0d_valid_cycle", sel), cyc, e.at);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        score(0, v0, rx_data0, pe0, fe0);
        score(1, v1, rx_data1, pe1, fe1);
    endtask

    // Drives one frame starting at the current negedge; returns just before the stop edge.
    task automatic frame(input int sel, input logic [7:0] d, input logic pb, input logic sb,
                         input int extra_at, input int rst_at);
        int   stop_seg;
        int   last;
        int   seg;
        bit   aborted;
        exp_t e;
        stop_seg = (sel == 1) ? 10 : 9;
        last     = OVS * stop_seg;
        aborted  = 1'b0;
        if (rst_at == 0) begin
            e.data = d;
            e.par  = (sel == 1) ? (pb != (^d)) : 1'b0;
            e.frm  = ~sb;
            e.at   = cyc + 1 + last;
            if (sel == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        if (sel == 0) de0 = 1'b1;
        else          de1 = 1'b1;
        rx_line = 1'b0;
        for (int m = 1; m <= last && !aborted; m++) begin
            step();
            de0 = 1'b0;
            de1 = 1'b0;
            if (m == extra_at) begin
                if (sel == 0) de0 = 1'b1;
                else          de1 = 1'b1;
            end
            if (m == 2) check($sformatf("dut%0d_busy_in_frame", sel), (sel == 0) ? busy0 : busy1, 1);
            if (m == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("async_rst_rx_data", rx_data0, 0);
                check("async_rst_rx_valid", v0, 0);
                check("async_rst_par_err", pe0, 0);
                check("async_rst_frm_err", fe0, 0);
                check("async_rst_busy", busy0, 0);
                step();
                rst_n   = 1'b1;
                rx_line = 1'b1;
                aborted = 1'b1;
            end else begin
                seg = (m + OVS / 2) / OVS;
                if (seg == 0)             rx_line = 1'b0;
                else if (seg <= 8)        rx_line = d[seg-1];
                else if (seg < stop_seg)  rx_line = pb;
                else                      rx_line = sb;
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_line = 1'b1;
        de0     = 1'b0;
        de1     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rx_data0", rx_data0, 0);
        check("reset_rx_valid0", v0, 0);
        check("reset_par_err0", pe0, 0);
        check("reset_frm_err0", fe0, 0);
        check("reset_busy0", busy0, 0);
        check("reset_rx_data1", rx_data1, 0);
        check("reset_busy1", busy1, 0);
        rst_n = 1'b1;
        step();

        // Plain 8N1 frame
        frame(0, 8'hA5, 1'b0, 1'b1, 0, 0);
        step();
        check("a5_busy_after", busy0, 0);
        repeat (4) step();

        // Even parity: correct bit, then wrong bit
        frame(1, 8'h07, 1'b1, 1'b1, 0, 0);
        step();
        check("par_ok_busy_after", busy1, 0);
        repeat (3) step();
        frame(1, 8'h07, 1'b0, 1'b1, 0, 0);
        step();
        repeat (3) step();

        // Stop bit low followed by a held-low line with start pulses
        frame(0, 8'h55, 1'b0, 1'b0, 0, 0);
        step();
        for (int i = 0; i < 100; i++) begin
            rx_line = 1'b0;
            de0     = (i % 13 == 0);
            step();
        end
        de0 = 1'b0;
        check("break_busy_held", busy0, 1);
        rx_line = 1'b1;
        step();
        step();
        check("break_exit_busy", busy0, 0);
        frame(0, 8'h3C, 1'b0, 1'b1, 0, 0);
        step();
        repeat (3) step();

        // Extra start pulse mid-frame
        frame(0, 8'h5A, 1'b0, 1'b1, 40, 0);
        step();
        check("restrike_busy_after", busy0, 0);
        repeat (3) step();

        // Reset mid-frame, then a fresh frame
        frame(0, 8'hC3, 1'b0, 1'b1, 0, 70);
        repeat (20) step();
        check("post_reset_busy", busy0, 0);
        frame(0, 8'hFF, 1'b0, 1'b1, 0, 0);
        step();
        repeat (3) step();

        // Back-to-back frames
        frame(0, 8'h12, 1'b0, 1'b1, 0, 0);
        step();
        frame(0, 8'h34, 1'b0, 1'b1, 0, 0);
        step();
        check("b2b_busy_after", busy0, 0);
        repeat (5) step();

        check("dut0_outstanding", q0.size(), 0);
        check("dut1_outstanding", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Receive-side frame assembler, directly downstream of the start-bit detector. It consumes the one-cycle start-detect pulse and the raw serial line, both on the same oversampled clock. It samples each data bit once per bit period, with an optional parity bit. It checks the stop bit and presents the received byte with a one-cycle valid strobe and error flags.

Parameters:
OVS, 16, clk cycles per bit period (oversampling ratio); 4..64
DATA_BITS, 8, data bits per frame, LSB first; 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd

Ports:
clk  input  1  oversampled bit clock, one sample per rising edge
rst_n  input  1  asynchronous active-low reset
RX_in  input  1  raw serial line, idle high
de_strtbit  input  1  one-cycle pulse from the start detector; start bit confirmed
rx_data  output  DATA_BITS  last received data word, LSB = first bit on line
rx_valid  output  1  one-cycle strobe; rx_data, par_err and frm_err are updated this cycle
par_err  output  1  parity mismatch on the frame flagged by rx_valid
frm_err  output  1  stop bit sampled low on the frame flagged by rx_valid
busy  output  1  high whenever state is not IDLE

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low (rst_n). All state is updated on the rising edge of clk.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, bit counter=0, sample counter=0, shift register=0.
  - rx_data=0, rx_valid=0, par_err=0, frm_err=0, busy=0.
  - Reset asserted mid-frame aborts the frame. No rx_valid is produced for it.
- States: IDLE, DATA, PAR, STOP, BREAK.
- IDLE:
  - On an edge with de_strtbit=1: go to DATA, sample counter=0, bit index=0.
  - Otherwise stay.
  - de_strtbit is ignored in every state other than IDLE.
- Sample counter:
  - Increments each clk in DATA, PAR and STOP.
  - At sample counter==OVS-1: sample RX_in, reset the counter to 0, advance.
- Timing: let T be the edge at which de_strtbit is sampled 1.
  - Data bit k (k=0..DATA_BITS-1) is sampled at edge T+OVS*(k+1).
  - Parity, if enabled, is sampled at T+OVS*(DATA_BITS+1).
  - Stop is sampled at T+OVS*(DATA_BITS+1+P), where P=1 if PARITY!=0, else 0.
- DATA:
  - Each sample is shifted into the MSB of a DATA_BITS shift register (right shift). After DATA_BITS shifts, bit 0 holds the first bit received.
  - After the last data sample: go to PAR if PARITY!=0, else go to STOP.
- PAR:
  - Compute expected = XOR of the data bits; invert it for odd parity.
  - Latch mismatch = (sampled bit != expected).
  - Go to STOP.
- STOP, at the stop sample edge:
  - rx_data <= shift register.
  - rx_valid=1 for exactly one cycle.
  - par_err <= the mismatch latched in PAR (0 when PARITY=0).
  - frm_err <= ~RX_in.
  - Next state: IDLE if RX_in=1, BREAK if RX_in=0.
- BREAK:
  - Stay until RX_in is sampled 1, then go to IDLE.
  - de_strtbit is ignored here, so a held-low line does not produce repeated frames.
- Output holding: rx_data, par_err and frm_err hold their values until the next rx_valid.
- busy: high in DATA, PAR, STOP and BREAK. It goes high the cycle after T and drops the cycle after the stop edge (or after BREAK exits).
- Back-to-back frames: a de_strtbit arriving the cycle after the return to IDLE is accepted. No dead cycle is required beyond the state transition.
- Counter widths: the sample counter is wide enough to hold OVS-1; the bit index is wide enough to hold DATA_BITS.

Test Plan:
- Defaults: pulse de_strtbit at T, drive byte 0xA5 LSB first with each bit held stable around T+16*(k+1), stop bit high -> rx_valid pulse at edge T+144, rx_data=0xA5, par_err=0, frm_err=0, busy low afterwards.
- PARITY=1: drive 0x07 with parity bit 1 -> rx_valid at T+160, par_err=0. Repeat with parity bit 0 -> par_err=1, rx_data=0x07.
- Stop bit low, then line held low for 100 cycles while de_strtbit pulses every 13 cycles -> exactly one rx_valid with frm_err=1, state stays BREAK with no further rx_valid. Line goes high -> IDLE. A subsequent 0x3C frame is received cleanly.
- de_strtbit pulsed again at T+40 during frame 0x5A -> ignored; rx_data=0x5A at T+144.
- rst_n pulsed low at T+70 mid-frame -> all outputs 0 immediately (asynchronously), no rx_valid. A fresh frame 0xFF afterwards is received correctly.
- Two frames 0x12 then 0x34, second de_strtbit one cycle after the first frame returns to IDLE -> two rx_valid pulses, with rx_data 0x12 then 0x34 and no errors.
